// File: rtl/chess_sound_pkg.sv
// Shared constants, melody ROM and pitch helpers for the chess sound sequencer.
// Melodies are packed as {length, note3, note2, note1, note0}; note0 plays first.
package chess_sound_pkg;

    localparam logic [2:0] SND_NONE    = 3'd0;
    localparam logic [2:0] SND_MOVE    = 3'd1;
    localparam logic [2:0] SND_CAPTURE = 3'd2;
    localparam logic [2:0] SND_CHECK   = 3'd3;
    localparam logic [2:0] SND_ILLEGAL = 3'd4;
    localparam logic [2:0] SND_PROMOTE = 3'd5;
    localparam logic [2:0] SND_WIN     = 3'd6;
    localparam logic [2:0] SND_LOSE    = 3'd7;

    localparam logic [2:0] P_A3 = 3'd0;
    localparam logic [2:0] P_C4 = 3'd1;
    localparam logic [2:0] P_E4 = 3'd2;
    localparam logic [2:0] P_G4 = 3'd3;
    localparam logic [2:0] P_C5 = 3'd4;
    localparam logic [2:0] P_E5 = 3'd5;
    localparam logic [2:0] P_G5 = 3'd6;
    localparam logic [2:0] P_A5 = 3'd7;

    localparam int unsigned PITCH_HZ [8] = '{220, 262, 330, 392, 523, 659, 784, 880};

    typedef struct packed {
        logic [2:0]       len;
        logic [3:0][2:0]  notes;
    } melody_t;

    typedef enum logic [1:0] {ST_IDLE, ST_TONE, ST_GAP} state_e;

    function automatic melody_t melody_rom(input logic [2:0] code);
        melody_t m;
        m.len   = 3'd0;
        m.notes = '0;
        case (code)
            SND_MOVE:    begin m.len = 3'd1; m.notes = {P_A3, P_A3, P_A3, P_C5}; end
            SND_CAPTURE: begin m.len = 3'd2; m.notes = {P_A3, P_A3, P_C5, P_E5}; end
            SND_CHECK:   begin m.len = 3'd2; m.notes = {P_A3, P_A3, P_A5, P_A5}; end
            SND_ILLEGAL: begin m.len = 3'd1; m.notes = {P_A3, P_A3, P_A3, P_A3}; end
            SND_PROMOTE: begin m.len = 3'd4; m.notes = {P_A5, P_G5, P_E5, P_C5}; end
            SND_WIN:     begin m.len = 3'd4; m.notes = {P_C5, P_G4, P_E4, P_C4}; end
            SND_LOSE:    begin m.len = 3'd4; m.notes = {P_A3, P_C4, P_E4, P_G4}; end
            default:     ;
        endcase
        return m;
    endfunction

    function automatic logic [17:0] half_cycles(input int unsigned clk_hz, input logic [2:0] pitch);
        return 18'(clk_hz / (2 * PITCH_HZ[pitch]));
    endfunction

endpackage

// File: rtl/chess_sound_seq_tone_divider.sv
// Square-wave generator: wave toggles every `half` enabled cycles, restarts high on load.
module tone_divider (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        en,
    input  logic [17:0] half,
    output logic        wave
);

    logic [17:0] cnt_q, cnt_d;
    logic        wave_q, wave_d;

    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (load) begin
            cnt_d  = 18'd0;
            wave_d = 1'b1;
        end else if (!en) begin
            cnt_d  = 18'd0;
            wave_d = 1'b0;
        end else if (cnt_q == half - 18'd1) begin
            cnt_d  = 18'd0;
            wave_d = ~wave_q;
        end else begin
            cnt_d  = cnt_q + 18'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= 18'd0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/chess_sound_seq.sv
// Plays a short square-wave melody on pwm for each non-zero sound_code strobe.
module chess_sound_seq
    import chess_sound_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned NOTE_MS = 120,
    parameter int unsigned GAP_MS  = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] sound_code,
    input  logic       play_sound,
    output logic       pwm,
    output logic       busy
);

    localparam logic [23:0] NOTE_LAST = 24'(CLK_HZ / 1000 * NOTE_MS - 1);
    localparam logic [23:0] GAP_LAST  = 24'(CLK_HZ / 1000 * GAP_MS - 1);

    state_e      state_q, state_d;
    logic [2:0]  code_q, code_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] dur_q, dur_d;
    logic        busy_q, busy_d;
    logic        load;
    logic        en;
    logic        strobe;
    logic [2:0]  next_idx;
    melody_t     mel;
    logic [17:0] half_sel;
    logic [17:0] half_tab [8];

    // Half-periods are folded to constants at elaboration; no runtime divider.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_half
            assign half_tab[gi] = half_cycles(CLK_HZ, 3'(gi));
        end
    endgenerate

    assign mel      = melody_rom(code_q);
    assign half_sel = half_tab[mel.notes[idx_q]];
    assign strobe   = play_sound && (sound_code != SND_NONE);
    assign next_idx = {1'b0, idx_q} + 3'd1;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        load    = 1'b0;
        case (state_q)
            ST_TONE: begin
                if (dur_q == NOTE_LAST) begin
                    state_d = ST_GAP;
                    dur_d   = 24'd0;
                end else begin
                    dur_d   = dur_q + 24'd1;
                end
            end
            ST_GAP: begin
                if (dur_q == GAP_LAST) begin
                    dur_d = 24'd0;
                    if (next_idx < mel.len) begin
                        state_d = ST_TONE;
                        idx_d   = next_idx[1:0];
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 2'd0;
                    end
                end else begin
                    dur_d = dur_q + 24'd1;
                end
            end
            default: ;
        endcase
        // A new event always wins, including over a note boundary in the same cycle.
        if (strobe) begin
            state_d = ST_TONE;
            code_d  = sound_code;
            idx_d   = 2'd0;
            dur_d   = 24'd0;
            load    = 1'b1;
        end
        en     = (state_d == ST_TONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            code_q  <= 3'd0;
            idx_q   <= 2'd0;
            dur_q   <= 24'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            busy_q  <= busy_d;
        end
    end

    tone_divider u_tone (
        .clk  (clk),
        .rstn (rstn),
        .load (load),
        .en   (en),
        .half (half_sel),
        .wave (pwm)
    );

    assign busy = busy_q;

endmodule

// File: tb/tb_chess_sound_seq.sv
// Randomized bench for chess_sound_seq against a cycle-position melody model.
module tb_chess_sound_seq;

    localparam int CLK_HZ   = 100_000;
    localparam int NOTE_MS  = 10;
    localparam int GAP_MS   = 2;
    localparam int NOTE_CYC = CLK_HZ / 1000 * NOTE_MS;
    localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
    localparam int PER      = NOTE_CYC + GAP_CYC;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] sound_code = 3'd0;
    logic       play_sound = 1'b0;
    logic       pwm;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: the melody is fully determined by its code and the edges since its strobe.
    bit m_active = 1'b0;
    int m_code = 0;
    int m_k = 0;
    int mel_len [8] = '{0, 1, 2, 2, 1, 4, 4, 4};
    int mel_hz [8][4] = '{
        '{0, 0, 0, 0},
        '{523, 0, 0, 0},
        '{659, 523, 0, 0},
        '{880, 880, 0, 0},
        '{220, 0, 0, 0},
        '{523, 659, 784, 880},
        '{262, 330, 392, 523},
        '{392, 330, 262, 220}
    };

    chess_sound_seq #(
        .CLK_HZ  (CLK_HZ),
        .NOTE_MS (NOTE_MS),
        .GAP_MS  (GAP_MS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sound_code (sound_code),
        .play_sound (play_sound),
        .pwm        (pwm),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_pwm();
        int note, w, half;
        if (!m_active) return 0;
        note = m_k / PER;
        w    = m_k % PER;
        if (w >= NOTE_CYC) return 0;
        half = CLK_HZ / (2 * mel_hz[m_code][note]);
        return ((w / half) % 2 == 0) ? 1 : 0;
    endfunction

    // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
    task automatic tick(input logic play, input logic [2:0] code);
        play_sound = play;
        sound_code = code;
        @(posedge clk);
        if (rstn) begin
            if (play && code != 3'd0) begin
                m_active = 1'b1;
                m_code   = int'(code);
                m_k      = 0;
            end else if (m_active) begin
                m_k++;
                if (m_k >= mel_len[m_code] * PER) m_active = 1'b0;
            end
        end
        #1;
        play_sound = 1'b0;
        sound_code = 3'($urandom_range(0, 7));
        check("pwm", int'(pwm), exp_pwm());
        check("busy", int'(busy), m_active ? 1 : 0);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (busy && guard < 6000) begin
            tick(1'b0, 3'd0);
            guard++;
        end
        check("drain_timeout", guard < 6000 ? 1 : 0, 1);
    endtask

    initial begin
        int run;
        int code;
        #1;
        check("reset_pwm", int'(pwm), 0);
        check("reset_busy", int'(busy), 0);
        idle(3);
        rstn = 1'b1;
        idle(500);

        // Single move note.
        tick(1'b1, 3'd1);
        idle(1250);

        // Promote: four notes, busy length measured directly.
        run = 0;
        tick(1'b1, 3'd5);
        if (busy) run++;
        for (int i = 0; i < 5000; i++) begin
            tick(1'b0, 3'd0);
            if (busy) run++;
        end
        check("promote_busy_len", run, 4 * PER);

        // Lose, retriggered by illegal at the 1500th busy cycle.
        tick(1'b1, 3'd7);
        idle(1498);
        tick(1'b1, 3'd4);
        run = 1;
        for (int i = 0; i < 1300; i++) begin
            tick(1'b0, 3'd0);
            if (busy) run++;
        end
        check("retrigger_busy_len", run, PER);

        // Capture with a code-0 strobe mid-note.
        tick(1'b1, 3'd2);
        idle(400);
        tick(1'b1, 3'd0);
        drain();
        idle(20);

        // Win, then asynchronous reset in the middle of the first tone.
        tick(1'b1, 3'd6);
        idle(300);
        #2 rstn = 1'b0;
        #1;
        m_active = 1'b0;
        check("async_rst_pwm", int'(pwm), 0);
        check("async_rst_busy", int'(busy), 0);
        idle(3);
        #2 rstn = 1'b1;
        idle(200);

        // Random events, retriggers, code-0 strobes and held strobes.
        for (int e = 0; e < 14; e++) begin
            code = $urandom_range(0, 7);
            tick(1'b1, 3'(code));
            if ($urandom_range(0, 3) == 0) tick(1'b1, 3'(code));
            idle($urandom_range(1, 3000));
        end
        drain();
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
